// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - op codes, FSM state encodings and default sizing for the data-memory controller
package dmem_access_ctrl_pkg;

   localparam int DMEM_DEPTH_DEF = 8;
   localparam int DMEM_LEN_W_DEF = 4;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_COPY  = 2'b10,
      OP_FILL  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_WR    = 3'd2,
      ST_CP_RD = 3'd3,
      ST_CP_WR = 3'd4,
      ST_FILL  = 3'd5,
      ST_RESP  = 3'd6
   } state_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - command/response handshake bundle between a requester and the controller
interface dmem_access_ctrl_if #(
   parameter int LEN_W = dmem_access_ctrl_pkg::DMEM_LEN_W_DEF
) ();
   import dmem_access_ctrl_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   op_e              cmd_op;
   logic [15:0]      cmd_addr;
   logic [15:0]      cmd_dst;
   logic [LEN_W-1:0] cmd_len;
   logic [15:0]      cmd_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [15:0]      rsp_rdata;
   logic             rsp_err;

   // master: core or debug host issuing commands
   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   // slave: the access controller
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_range_chk.sv
// rtl/dmem_range_chk.sv - combinational check that base+len stays within DEPTH words
module dmem_range_chk #(
   parameter int DEPTH = 8,
   parameter int LEN_W = 4
) (
   input  logic [15:0]      base,
   input  logic [LEN_W-1:0] len,
   output logic             in_range
);

   // 17-bit sum so a base near 0xFFFF cannot wrap back into range
   logic [16:0] end_addr;

   assign end_addr = {1'b0, base} + 17'(len);
   assign in_range = (end_addr <= 17'(DEPTH));

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory initiator: single read/write plus copy/fill sequencing
// Optional: define DMEM_SUM_EN to return a 16-bit wrap-around sum of copied words on COPY.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH_DEF,
   parameter int LEN_W = DMEM_LEN_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   dmem_access_ctrl_if.slave   bus,
   output logic                busy,
   output logic [15:0]         mem_access_addr,
   output logic [15:0]         mem_write_data,
   output logic                mem_write_en,
   output logic                mem_read,
   input  logic [15:0]         mem_read_data
);

   state_e           state;
   logic [15:0]      src_q;
   logic [15:0]      dst_q;
   logic [15:0]      wdata_q;
   logic [15:0]      hold_q;
   logic [15:0]      rdata_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic             err_q;

   logic             src_ok;
   logic             dst_ok;
   logic             cmd_ok;
   logic             last_word;
   logic [LEN_W-1:0] src_chk_len;

   // single-word ops are checked as a one-word span, giving addr < DEPTH
   always_comb begin
      src_chk_len = bus.cmd_len;
      if (bus.cmd_op == OP_READ || bus.cmd_op == OP_WRITE)
         src_chk_len = LEN_W'(1);
   end

   dmem_range_chk #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_src_chk (
      .base     (bus.cmd_addr),
      .len      (src_chk_len),
      .in_range (src_ok)
   );

   dmem_range_chk #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_dst_chk (
      .base     (bus.cmd_dst),
      .len      (bus.cmd_len),
      .in_range (dst_ok)
   );

   assign cmd_ok    = src_ok && ((bus.cmd_op != OP_COPY) || dst_ok);
   assign last_word = (cnt_q == len_q - LEN_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         wdata_q <= '0;
         hold_q  <= '0;
         rdata_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  src_q   <= bus.cmd_addr;
                  dst_q   <= bus.cmd_dst;
                  len_q   <= bus.cmd_len;
                  wdata_q <= bus.cmd_wdata;
                  cnt_q   <= '0;
                  rdata_q <= '0;
                  err_q   <= !cmd_ok;
                  if (!cmd_ok) begin
                     state <= ST_RESP;
                  end else begin
                     case (bus.cmd_op)
                        OP_READ:  state <= ST_RD;
                        OP_WRITE: state <= ST_WR;
                        OP_COPY:  state <= (bus.cmd_len == '0) ? ST_RESP : ST_CP_RD;
                        default:  state <= (bus.cmd_len == '0) ? ST_RESP : ST_FILL;
                     endcase
                  end
               end
            end
            ST_RD: begin
               rdata_q <= mem_read_data;
               state   <= ST_RESP;
            end
            ST_WR: begin
               state <= ST_RESP;
            end
            ST_CP_RD: begin
               hold_q <= mem_read_data;
`ifdef DMEM_SUM_EN
               rdata_q <= rdata_q + mem_read_data;
`endif
               state  <= ST_CP_WR;
            end
            ST_CP_WR: begin
               // ascending order keeps overlapping copies sequentially consistent
               if (last_word) begin
                  state <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + LEN_W'(1);
                  src_q <= src_q + 16'd1;
                  dst_q <= dst_q + 16'd1;
                  state <= ST_CP_RD;
               end
            end
            ST_FILL: begin
               if (last_word) begin
                  state <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + LEN_W'(1);
                  src_q <= src_q + 16'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  err_q <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // memory strobes decode from state alone so reset drops them at once
   always_comb begin
      mem_read        = 1'b0;
      mem_write_en    = 1'b0;
      mem_access_addr = 16'd0;
      mem_write_data  = 16'd0;
      case (state)
         ST_RD, ST_CP_RD: begin
            mem_read        = 1'b1;
            mem_access_addr = src_q;
         end
         ST_WR, ST_FILL: begin
            mem_write_en    = 1'b1;
            mem_access_addr = src_q;
            mem_write_data  = wdata_q;
         end
         ST_CP_WR: begin
            mem_write_en    = 1'b1;
            mem_access_addr = dst_q;
            mem_write_data  = hold_q;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready = (state == ST_IDLE);
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
   import dmem_access_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;

   logic [15:0] mem [0:7];
   logic        tb_we = 1'b0;
   logic [2:0]  tb_wa = 3'd0;
   logic [15:0] tb_wd = 16'd0;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cyc   = 0;
   int wr_cyc   = 0;
   int both_cyc = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl_if bus ();

   dmem_access_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus.slave),
      .busy            (busy),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   assign mem_read_data = (mem_read && mem_access_addr < 16'd8) ? mem[mem_access_addr[2:0]] : 16'd0;

   always @(posedge clk) begin
      if (mem_write_en && mem_access_addr < 16'd8)
         mem[mem_access_addr[2:0]] <= mem_write_data;
      else if (tb_we)
         mem[tb_wa] <= tb_wd;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_read)                 rd_cyc++;
         if (mem_write_en)             wr_cyc++;
         if (mem_read && mem_write_en) both_cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic issue(input op_e op, input logic [15:0] addr, input logic [15:0] dst,
                        input logic [3:0] len, input logic [15:0] wd);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr;
      bus.cmd_dst = dst; bus.cmd_len = len; bus.cmd_wdata = wd;
      rd_cyc = 0; wr_cyc = 0;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [15:0] rd, output logic er, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 50);
      if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   task automatic run_cmd(input op_e op, input logic [15:0] addr, input logic [15:0] dst,
                          input logic [3:0] len, input logic [15:0] wd,
                          output logic [15:0] rd, output logic er, output int lat);
      issue(op, addr, dst, len, wd);
      wait_rsp(rd, er, lat);
   endtask

   initial begin
      logic [15:0] rd;
      logic        er;
      int          lat;
      logic        seen;
      logic [15:0] exp_sum;

      bus.cmd_valid = 1'b0; bus.cmd_op = OP_READ; bus.cmd_addr = 16'd0;
      bus.cmd_dst = 16'd0; bus.cmd_len = 4'd0; bus.cmd_wdata = 16'd0;
      bus.rsp_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_mem_read", {31'd0, mem_read}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_outs", {mem_access_addr, mem_write_data}, 32'd0);
      check("rst_strobes", {28'd0, mem_write_en, bus.rsp_err, busy, mem_read}, 32'd0);
      check("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);

      poke(3'd0, 16'd6); poke(3'd1, 16'd1); poke(3'd2, 16'd1); poke(3'd3, 16'd0);
      poke(3'd4, 16'd0); poke(3'd5, 16'd0); poke(3'd6, 16'd0); poke(3'd7, 16'd5);

      // READ addr 7
      issue(OP_READ, 16'd7, 16'd0, 4'd0, 16'd0);
      @(negedge clk);
      check("t1_mem_read_c1", {31'd0, mem_read}, 32'd1);
      check("t1_addr_c1", {16'd0, mem_access_addr}, 32'd7);
      @(negedge clk);
      check("t1_rsp_valid_c2", {31'd0, bus.rsp_valid}, 32'd1);
      check("t1_rdata", {16'd0, bus.rsp_rdata}, 32'd5);
      check("t1_err", {31'd0, bus.rsp_err}, 32'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;

      // WRITE then READ back
      run_cmd(OP_WRITE, 16'd3, 16'd0, 4'd0, 16'hBEEF, rd, er, lat);
      check("t2_wr_pulses", wr_cyc, 32'd1);
      check("t2_wr_lat", lat, 32'd2);
      check("t2_wr_rdata", {15'd0, er, rd}, 32'd0);
      run_cmd(OP_READ, 16'd3, 16'd0, 4'd0, 16'd0, rd, er, lat);
      check("t2_rd_data", {16'd0, rd}, 32'h0000BEEF);

      // COPY 0..2 -> 4..6
      run_cmd(OP_COPY, 16'd0, 16'd4, 4'd3, 16'd0, rd, er, lat);
`ifdef DMEM_SUM_EN
      exp_sum = 16'd8;
`else
      exp_sum = 16'd0;
`endif
      check("t3_rdata", {16'd0, rd}, {16'd0, exp_sum});
      check("t3_err", {31'd0, er}, 32'd0);
      check("t3_mem_cycles", rd_cyc + wr_cyc, 32'd6);
      check("t3_lat", lat, 32'd7);
      check("t3_words", {mem[4], mem[5]}, {16'd6, 16'd1});
      check("t3_word6", {16'd0, mem[6]}, 32'd1);
      check("t3_no_overlap_strobe", both_cyc, 32'd0);

      // range errors and zero length
      run_cmd(OP_FILL, 16'd6, 16'd0, 4'd3, 16'h1111, rd, er, lat);
      check("t4_fill_err", {31'd0, er}, 32'd1);
      check("t4_fill_no_wr", wr_cyc, 32'd0);
      check("t4_fill_lat", lat, 32'd1);
      run_cmd(OP_READ, 16'd8, 16'd0, 4'd0, 16'd0, rd, er, lat);
      check("t4_read8_err", {31'd0, er}, 32'd1);
      check("t4_read8_no_rd", rd_cyc, 32'd0);
      run_cmd(OP_FILL, 16'd2, 16'd0, 4'd0, 16'h2222, rd, er, lat);
      check("t4_len0", {15'd0, er, rd}, 32'd0);
      check("t4_len0_cycles", rd_cyc + wr_cyc, 32'd0);
      run_cmd(OP_COPY, 16'd0, 16'd6, 4'd3, 16'd0, rd, er, lat);
      check("t4_copy_dst_err", {31'd0, er}, 32'd1);
      run_cmd(OP_FILL, 16'd5, 16'd0, 4'd3, 16'h00A5, rd, er, lat);
      check("t4_fill_edge_err", {31'd0, er}, 32'd0);
      check("t4_fill_edge_wr", wr_cyc, 32'd3);
      check("t4_fill_edge_mem", {mem[5], mem[7]}, 32'h00A500A5);

      poke(3'd0, 16'd11); poke(3'd1, 16'd22); poke(3'd2, 16'd33); poke(3'd3, 16'd44);
      poke(3'd4, 16'd0);  poke(3'd5, 16'd0);  poke(3'd6, 16'd0);  poke(3'd7, 16'd0);

      // response back-pressure with a queued command
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = 16'd0;
      rd_cyc = 0; wr_cyc = 0;
      @(posedge clk);
      #1 bus.cmd_op = OP_WRITE; bus.cmd_addr = 16'd1; bus.cmd_wdata = 16'h1234;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 50);
      check("t5_lat", lat, 32'd2);
      for (int i = 0; i < 5; i++) begin
         check("t5_hold", {14'd0, bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata}, {14'd0, 2'b10, 16'd11});
         @(negedge clk);
      end
      check("t5_not_accepted", wr_cyc, 32'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("t5_ready_after", {30'd0, bus.cmd_ready, busy}, 32'd2);
      check("t5_still_no_wr", wr_cyc, 32'd0);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      wait_rsp(rd, er, lat);
      check("t5_wr_lat", lat, 32'd2);
      check("t5_wr_mem", {16'd0, mem[1]}, 32'h00001234);

      // reset during COPY len 4
      issue(OP_COPY, 16'd0, 16'd4, 4'd4, 16'd0);
      repeat (4) @(negedge clk);
      check("t6_pre_rst_wr", {31'd0, mem_write_en}, 32'd1);
      rst = 1'b1;
      #1;
      check("t6_strobes_drop", {30'd0, mem_write_en, mem_read}, 32'd0);
      check("t6_addr_zero", {16'd0, mem_access_addr}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      check("t6_no_rsp", {31'd0, seen}, 32'd0);
      check("t6_word0", {16'd0, mem[4]}, 32'd11);
      check("t6_word1", {16'd0, mem[5]}, 32'd0);
      check("t6_words23", {mem[6], mem[7]}, 32'd0);
      check("t6_idle", {30'd0, bus.cmd_ready, busy}, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
